// File: rtl/gnrl_freelist128_module.sv
`default_nettype none
// ============================================================================
// Module      : gnrl_freelist128_module
// Description : 128-entry free-list allocator. Offers one reserved free index
//               per cycle in round-robin order from a rotating start pointer
//               and accepts up to two index releases per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module gnrl_freelist128_module (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_alloc_req,
    output logic       o_alloc_vld,
    output logic [6:0] o_alloc_idx,
    input  logic       i_free0_vld,
    input  logic [6:0] i_free0_idx,
    input  logic       i_free1_vld,
    input  logic [6:0] i_free1_idx,
    output logic [7:0] o_free_cnt,
    output logic       o_empty,
    output logic       o_err
);

    localparam logic [127:0] ALL_FREE  = {128{1'b1}};
    localparam logic [7:0]   FULL_CNT  = 8'd128;

    // map bit set = entry free and not sitting in the offer slot
    logic [127:0] map;
    logic [6:0]   ptr;

    logic         hi_hit;
    logic [6:0]   hi_idx;
    logic         any_hit;
    logic [6:0]   any_idx;
    logic         cand_vld;
    logic [6:0]   cand;

    logic         alloc;
    logic         load;
    logic         rel0_ok;
    logic         rel1_ok;
    logic         err_set;
    logic [127:0] map_nxt;
    logic [7:0]   cnt_nxt;

    // Round-robin search: lowest free index at/above ptr, else lowest overall.
    // The loop walks downward so the last hit written is the lowest index.
    always_comb begin
        hi_hit  = 1'b0;
        hi_idx  = 7'd0;
        any_hit = 1'b0;
        any_idx = 7'd0;
        for (int i = 127; i >= 0; i--) begin
            if (map[i]) begin
                any_hit = 1'b1;
                any_idx = 7'(i);
                if (7'(i) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = 7'(i);
                end
            end
        end
    end

    assign cand_vld = hi_hit | any_hit;
    assign cand     = hi_hit ? hi_idx : any_idx;

    // A request without a valid offer is simply ignored.
    assign alloc = i_alloc_req & o_alloc_vld;
    // Slot refills whenever it is empty or being consumed this edge.
    assign load  = (~o_alloc_vld | alloc) & cand_vld;

    // A release is legal only for an entry that is truly outstanding: not
    // already free, not the one on offer, and not duplicated across ports.
    assign rel0_ok = i_free0_vld & ~map[i_free0_idx]
                   & ~(o_alloc_vld & (i_free0_idx == o_alloc_idx));
    assign rel1_ok = i_free1_vld & ~map[i_free1_idx]
                   & ~(o_alloc_vld & (i_free1_idx == o_alloc_idx))
                   & ~(i_free0_vld & (i_free1_idx == i_free0_idx));
    assign err_set = (i_free0_vld & ~rel0_ok) | (i_free1_vld & ~rel1_ok);

    // Next map: reserve the candidate, set released bits. The two never
    // collide because a candidate bit is 1 and a legal release bit is 0.
    always_comb begin
        map_nxt = map;
        if (load) begin
            map_nxt[cand] = 1'b0;
        end
        if (rel0_ok) begin
            map_nxt[i_free0_idx] = 1'b1;
        end
        if (rel1_ok) begin
            map_nxt[i_free1_idx] = 1'b1;
        end
    end

    // Free count includes the reserved slot, so only a completed handshake
    // decrements it.
    assign cnt_nxt = o_free_cnt + {7'd0, rel0_ok} + {7'd0, rel1_ok} - {7'd0, alloc};

    // State update: reset, then flush, then normal alloc/release traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            map         <= ALL_FREE;
            o_alloc_vld <= 1'b0;
            o_alloc_idx <= 7'd0;
            ptr         <= 7'd0;
            o_free_cnt  <= FULL_CNT;
            o_err       <= 1'b0;
        end else if (i_flush) begin
            map         <= ALL_FREE;
            o_alloc_vld <= 1'b0;
            ptr         <= 7'd0;
            o_free_cnt  <= FULL_CNT;
        end else begin
            map        <= map_nxt;
            o_free_cnt <= cnt_nxt;
            if (load) begin
                o_alloc_vld <= 1'b1;
                o_alloc_idx <= cand;
                ptr         <= cand + 7'd1;
            end else if (alloc) begin
                o_alloc_vld <= 1'b0;
            end
            if (err_set) begin
                o_err <= 1'b1;
            end
        end
    end

    assign o_empty = (o_free_cnt == 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_gnrl_freelist128_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_gnrl_freelist128_module
// Description : Directed self-checking bench for gnrl_freelist128_module.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gnrl_freelist128_module;

    logic       clk;
    logic       rst;
    logic       i_flush;
    logic       i_alloc_req;
    logic       o_alloc_vld;
    logic [6:0] o_alloc_idx;
    logic       i_free0_vld;
    logic [6:0] i_free0_idx;
    logic       i_free1_vld;
    logic [6:0] i_free1_idx;
    logic [7:0] o_free_cnt;
    logic       o_empty;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    gnrl_freelist128_module dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_alloc_req (i_alloc_req),
        .o_alloc_vld (o_alloc_vld),
        .o_alloc_idx (o_alloc_idx),
        .i_free0_vld (i_free0_vld),
        .i_free0_idx (i_free0_idx),
        .i_free1_vld (i_free1_vld),
        .i_free1_idx (i_free1_idx),
        .o_free_cnt  (o_free_cnt),
        .o_empty     (o_empty),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_frees();
        i_free0_vld = 1'b0;
        i_free1_vld = 1'b0;
        i_free0_idx = 7'd0;
        i_free1_idx = 7'd0;
    endtask

    initial begin
        rst         = 1'b1;
        i_flush     = 1'b0;
        i_alloc_req = 1'b0;
        clear_frees();

        // ---- Reset values --------------------------------------------------
        step();
        step();
        check("rst_vld",   32'(o_alloc_vld), 32'd0);
        check("rst_idx",   32'(o_alloc_idx), 32'd0);
        check("rst_cnt",   32'(o_free_cnt),  32'd128);
        check("rst_empty", 32'(o_empty),     32'd0);
        check("rst_err",   32'(o_err),       32'd0);

        // ---- Sweep: hold request, expect 0..127 then drain -----------------
        rst         = 1'b0;
        i_alloc_req = 1'b1;
        check("first_vld_low", 32'(o_alloc_vld), 32'd0);
        step();
        for (int k = 0; k < 128; k++) begin
            check("sweep_vld", 32'(o_alloc_vld), 32'd1);
            check("sweep_idx", 32'(o_alloc_idx), 32'(k));
            check("sweep_cnt", 32'(o_free_cnt),  32'(128 - k));
            step();
        end
        check("sweep_drain_vld", 32'(o_alloc_vld), 32'd0);
        check("sweep_cnt0",      32'(o_free_cnt),  32'd0);
        check("sweep_empty",     32'(o_empty),     32'd1);
        step();
        check("sweep_hold_vld",  32'(o_alloc_vld), 32'd0);

        // ---- Full, then a single release of 77 -----------------------------
        i_alloc_req = 1'b0;
        i_free0_vld = 1'b1;
        i_free0_idx = 7'd77;
        step();
        clear_frees();
        check("r77_cnt",   32'(o_free_cnt),  32'd1);
        check("r77_vld0",  32'(o_alloc_vld), 32'd0);
        check("r77_empty", 32'(o_empty),     32'd0);
        check("r77_err",   32'(o_err),       32'd0);
        step();
        check("r77_vld1",  32'(o_alloc_vld), 32'd1);
        check("r77_idx",   32'(o_alloc_idx), 32'd77);
        i_alloc_req = 1'b1;
        step();
        i_alloc_req = 1'b0;
        check("r77_take_vld", 32'(o_alloc_vld), 32'd0);
        check("r77_take_cnt", 32'(o_free_cnt),  32'd0);

        // ---- Wrap search: take 0..9, release 3 and 5, continue -------------
        do_reset();
        i_alloc_req = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            check("wrap_pre_idx", 32'(o_alloc_idx), 32'(k));
            step();
        end
        check("wrap_cnt118", 32'(o_free_cnt),  32'd118);
        check("wrap_idx10",  32'(o_alloc_idx), 32'd10);
        i_free0_vld = 1'b1;
        i_free0_idx = 7'd3;
        i_free1_vld = 1'b1;
        i_free1_idx = 7'd5;
        step();
        clear_frees();
        check("wrap_cnt119", 32'(o_free_cnt), 32'd119);
        for (int j = 0; j < 119; j++) begin
            int e;
            e = (j < 117) ? (11 + j) : ((j == 117) ? 3 : 5);
            check("wrap_vld", 32'(o_alloc_vld), 32'd1);
            check("wrap_idx", 32'(o_alloc_idx), 32'(e));
            step();
        end
        check("wrap_end_vld", 32'(o_alloc_vld), 32'd0);
        check("wrap_end_cnt", 32'(o_free_cnt),  32'd0);
        check("wrap_end_err", 32'(o_err),       32'd0);

        // ---- Release of an already free index (72) -------------------------
        do_reset();
        i_alloc_req = 1'b0;
        step();
        check("dbl72_slot", 32'(o_alloc_idx), 32'd0);
        i_free0_vld = 1'b1;
        i_free0_idx = 7'd72;
        step();
        clear_frees();
        check("dbl72_err", 32'(o_err),       32'd1);
        check("dbl72_cnt", 32'(o_free_cnt),  32'd128);

        // ---- Same allocated index 40 on both ports -------------------------
        do_reset();
        check("rst_clears_err", 32'(o_err), 32'd0);
        i_alloc_req = 1'b1;
        step();
        for (int k = 0; k <= 40; k++) begin
            check("pre40_idx", 32'(o_alloc_idx), 32'(k));
            step();
        end
        check("pre40_cnt", 32'(o_free_cnt), 32'd87);
        i_alloc_req = 1'b0;
        i_free0_vld = 1'b1;
        i_free0_idx = 7'd40;
        i_free1_vld = 1'b1;
        i_free1_idx = 7'd40;
        step();
        clear_frees();
        check("dup40_cnt", 32'(o_free_cnt),  32'd88);
        check("dup40_err", 32'(o_err),       32'd1);
        check("dup40_idx", 32'(o_alloc_idx), 32'd41);

        // ---- Alloc plus two legal releases at cnt=50 -----------------------
        i_alloc_req = 1'b1;
        for (int k = 41; k <= 78; k++) begin
            check("to50_idx", 32'(o_alloc_idx), 32'(k));
            step();
        end
        check("cnt50", 32'(o_free_cnt), 32'd50);
        i_free0_vld = 1'b1;
        i_free0_idx = 7'd10;
        i_free1_vld = 1'b1;
        i_free1_idx = 7'd20;
        step();
        clear_frees();
        check("sim_cnt51", 32'(o_free_cnt),  32'd51);
        check("sim_idx80", 32'(o_alloc_idx), 32'd80);

        // ---- Flush mid-stream after 20 more allocations --------------------
        for (int k = 0; k < 20; k++) begin
            step();
        end
        check("preflush_idx", 32'(o_alloc_idx), 32'd100);
        check("preflush_cnt", 32'(o_free_cnt),  32'd31);
        i_flush = 1'b1;
        step();
        i_flush     = 1'b0;
        i_alloc_req = 1'b0;
        check("flush_cnt",   32'(o_free_cnt),  32'd128);
        check("flush_vld",   32'(o_alloc_vld), 32'd0);
        check("flush_err",   32'(o_err),       32'd1);
        check("flush_empty", 32'(o_empty),     32'd0);
        step();
        check("postflush_vld", 32'(o_alloc_vld), 32'd1);
        check("postflush_idx", 32'(o_alloc_idx), 32'd0);
        check("postflush_cnt", 32'(o_free_cnt),  32'd128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
